// File: rtl/llr_frame_feeder.sv
// Saturates streamed channel LLRs into two ping-pong frame banks and replays each full
// bank to the SCAN decoder as an unbroken N-cycle burst followed by a fixed decode window.
module llr_frame_feeder #(
    parameter int N          = 1024,
    parameter int Q          = 6,
    parameter int IN_W       = 8,
    parameter int DEC_CYCLES = 3000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_llr,
    output logic signed [Q-1:0]    in_LLR,
    output logic                   channel,
    output logic                   busy,
    output logic                   dec_done
);
    localparam int AW      = $clog2(N);
    localparam int DW      = $clog2(DEC_CYCLES + 1);
    localparam int SAT_MAX = 2 ** (Q - 1) - 1;
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] SAT_LO = -SAT_HI;

    // state | meaning: IDLE wait for full bank, PREP read entry 0, BURST stream N LLRs,
    //                  DECODE hold channel=1, DONE dec_done pulse
    typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_BURST, ST_DECODE, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]       dec_cnt_q, dec_cnt_d;
    logic                ready_q;
    logic signed [Q-1:0] mem [2*N];
    logic signed [Q-1:0] rd_data_q;
    logic signed [Q-1:0] llr_sat;
    logic                wr_en, wr_last, rd_last;
    logic [AW-1:0]       rd_idx;
    logic [AW:0]         rd_addr, wr_addr;

    always_comb begin
        if (s_llr > SAT_HI) begin
            llr_sat = SAT_HI[Q-1:0];
        end else if (s_llr < SAT_LO) begin
            llr_sat = SAT_LO[Q-1:0];
        end else begin
            llr_sat = s_llr[Q-1:0];
        end
    end

    // ready_q keeps s_ready low for the reset cycle itself
    assign s_ready = ready_q & ~full_q[wr_bank_q];
    assign wr_en   = s_valid & s_ready;
    assign wr_addr = {wr_bank_q, wr_cnt_q};
    assign rd_addr = {rd_bank_q, rd_idx};
    assign in_LLR  = (state_q == ST_BURST) ? rd_data_q : '0;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        wr_last   = 1'b0;
        if (wr_en) begin
            if (wr_cnt_q == AW'(N - 1)) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
                wr_last   = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        dec_cnt_d = dec_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_last   = 1'b0;
        rd_idx    = '0;
        channel   = 1'b1;
        busy      = 1'b0;
        dec_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) state_d = ST_PREP;
            end
            ST_PREP: begin
                busy     = 1'b1;
                rd_cnt_d = '0;
                state_d  = ST_BURST;
            end
            ST_BURST: begin
                busy    = 1'b1;
                channel = 1'b0;
                rd_idx  = rd_cnt_q + 1'b1;
                if (rd_cnt_q == AW'(N - 1)) begin
                    rd_last   = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    dec_cnt_d = DW'(DEC_CYCLES - 1);
                    state_d   = ST_DECODE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                busy = 1'b1;
                if (dec_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    dec_cnt_d = dec_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                dec_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // set and clear always target different banks, so both apply
    always_comb begin
        full_d = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            dec_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            ready_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= llr_sat;
        rd_data_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_llr_frame_feeder.sv
// Directed bench for llr_frame_feeder: saturation table, back-to-back frames,
// backpressure, gappy input and reset during a burst, checked by an output monitor.
module tb_llr_frame_feeder;
    localparam int N          = 1024;
    localparam int Q          = 6;
    localparam int IN_W       = 8;
    localparam int DEC_CYCLES = 3000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic signed [IN_W-1:0] s_llr = '0;
    logic signed [Q-1:0]    in_LLR;
    logic                   channel, busy, dec_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic signed [Q-1:0] exp_q[$];
    bit stop_drv   = 1'b0;
    bit drv_active = 1'b0;
    int f_st, f_la;

    int mon_bidx = 0, mon_nburst = 0, mon_ndone = 0, mon_bstart = 0, mon_done_cyc = 0, mon_dcnt = 0;
    bit mon_in_dec = 1'b0;
    bit rst_seen   = 1'b1;
    logic p_busy = 1'b0, pp_busy = 1'b0, p_chan = 1'b1, p_ready = 1'b0;

    typedef struct {
        logic signed [IN_W-1:0] llr;
        logic signed [Q-1:0]    exp;
    } vec_t;
    vec_t tbl[12];

    llr_frame_feeder #(.N(N), .Q(Q), .IN_W(IN_W), .DEC_CYCLES(DEC_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_llr    (s_llr),
        .in_LLR   (in_LLR),
        .channel  (channel),
        .busy     (busy),
        .dec_done (dec_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void set_vec(input int i, input int in_v, input int ex_v);
        tbl[i].llr = IN_W'(in_v);
        tbl[i].exp = Q'(ex_v);
    endfunction

    function automatic logic signed [IN_W-1:0] gen_in(input int kind, input int k);
        if (kind == 0) begin
            if (k < 12) return tbl[k].llr;
            return IN_W'(k % 20);
        end
        return IN_W'((k * 7 + kind * 13) % 63 - 31);
    endfunction

    function automatic logic signed [Q-1:0] gen_exp(input int kind, input int k);
        if (kind == 0) begin
            if (k < 12) return tbl[k].exp;
            return Q'(k % 20);
        end
        return Q'((k * 7 + kind * 13) % 63 - 31);
    endfunction

    // duty = percentage of cycles in which a beat is offered
    task automatic send_frame(input int kind, input int duty, output int stalls, output int last_acc);
        bit done;
        stalls   = 0;
        last_acc = 0;
        for (int k = 0; k < N; k++) begin
            done = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                if (stop_drv) begin
                    s_valid = 1'b0;
                    return;
                end
                if (duty < 100 && $urandom_range(99) >= duty) begin
                    s_valid = 1'b0;
                end else begin
                    s_valid = 1'b1;
                    s_llr   = gen_in(kind, k);
                    @(negedge clk);
                    if (s_ready) begin
                        exp_q.push_back(gen_exp(kind, k));
                        last_acc = cyc + 1;
                        done     = 1'b1;
                    end else begin
                        stalls++;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_llr   = '0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int t = 0;
        while (mon_ndone < target && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (mon_ndone < target) chk(name, mon_ndone, target);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_bidx   = 0;
            mon_in_dec = 1'b0;
            mon_dcnt   = 0;
            rst_seen   = 1'b1;
        end else begin
            if (!channel) begin
                if (mon_bidx == 0) begin
                    chk("prep_before_burst", {pp_busy, p_busy, p_chan}, 3'b011);
                    mon_bstart = cyc;
                    mon_nburst++;
                end
                chk("burst_busy", busy, 1);
                if (exp_q.size() > 0) chk("burst_data", in_LLR, exp_q.pop_front());
                else chk("burst_beat_queued", exp_q.size(), 1);
                mon_bidx++;
            end else begin
                chk("llr_zero_outside_burst", in_LLR, 0);
                if (mon_bidx != 0) begin
                    chk("burst_len", mon_bidx, N);
                    mon_bidx   = 0;
                    mon_in_dec = 1'b1;
                    mon_dcnt   = 0;
                end
                if (mon_in_dec && busy) mon_dcnt++;
            end
            chk("dec_done", dec_done, (mon_in_dec && !busy) ? 1 : 0);
            if (mon_in_dec && !busy) begin
                chk("decode_len", mon_dcnt, DEC_CYCLES);
                mon_in_dec   = 1'b0;
                mon_ndone++;
                mon_done_cyc = cyc;
            end
            if (s_ready && !p_ready) begin
                if (rst_seen) rst_seen = 1'b0;
                else chk("ready_rise_after_burst", {p_chan, channel}, 2'b01);
            end
        end
        pp_busy = p_busy;
        p_busy  = busy;
        p_chan  = channel;
        p_ready = s_ready;
    end

    initial begin
        #(950000);
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, la, st6, d1, t;
        set_vec(0, 40, 31);    set_vec(1, -128, -31); set_vec(2, -31, -31); set_vec(3, 5, 5);
        set_vec(4, 31, 31);    set_vec(5, 32, 31);    set_vec(6, -32, -31); set_vec(7, 127, 31);
        set_vec(8, 0, 0);      set_vec(9, -1, -1);    set_vec(10, -30, -30); set_vec(11, 19, 19);

        // reset values
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_llr", in_LLR, 0);
        chk("rst_channel", channel, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dec_done", dec_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("rst_ready_still_low", s_ready, 0);
        @(negedge clk); chk("rst_ready_high", s_ready, 1);

        // 1: saturation table + single frame
        send_frame(0, 100, st, la);
        idle();
        chk("t1_no_stall", st, 0);
        wait_done(1, N + DEC_CYCLES + 100, "t1_done_timeout");
        chk("t1_burst_start", mon_bstart, la + 2);
        @(negedge clk);
        chk("t1_busy_after_done", busy, 0);
        chk("t1_done_one_cycle", dec_done, 0);

        // 2: second frame streamed during first decode
        send_frame(1, 100, st, la);
        idle();
        t = 0;
        while (!mon_in_dec && t < 2 * N) begin @(posedge clk); #1; t++; end
        chk("t2_decode_reached", mon_in_dec, 1);
        send_frame(2, 100, st, la);
        idle();
        chk("t2_no_stall", st, 0);
        wait_done(2, N + DEC_CYCLES + 100, "t2_done1_timeout");
        d1 = mon_done_cyc;
        t = 0;
        while (mon_nburst < 3 && t < 20) begin @(posedge clk); #1; t++; end
        chk("t2_second_burst_gap", mon_bstart - d1, 3);
        wait_done(3, N + DEC_CYCLES + 100, "t2_done2_timeout");

        // 3: four frames back to back, the last one must wait for a free bank
        send_frame(3, 100, st, la);
        send_frame(4, 100, st, la);
        send_frame(5, 100, st, la);
        send_frame(6, 100, st6, la);
        idle();
        chk("t3_backpressure_seen", (st6 > 0) ? 1 : 0, 1);
        wait_done(7, 5 * (N + DEC_CYCLES + 10), "t3_done_timeout");

        // 4: gappy input, 30% offer rate
        send_frame(7, 30, st, la);
        send_frame(8, 30, st, la);
        idle();
        wait_done(9, 4 * (N + DEC_CYCLES + 10), "t4_done_timeout");
        chk("t4_burst_count", mon_nburst, 9);

        // 5: reset at burst beat 100 while the next frame is partly loaded
        send_frame(9, 100, st, la);
        fork
            begin
                drv_active = 1'b1;
                send_frame(10, 100, f_st, f_la);
                drv_active = 1'b0;
            end
        join_none
        t = 0;
        while (mon_bidx < 100 && t < 2 * N) begin @(posedge clk); #1; t++; end
        chk("t5_reach_beat100", (mon_bidx >= 100) ? 1 : 0, 1);
        rst      = 1'b1;
        stop_drv = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_rst_channel", channel, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_llr", in_LLR, 0);
        chk("t5_rst_s_ready", s_ready, 0);
        chk("t5_rst_dec_done", dec_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("t5_ready_low_in_reset", s_ready, 0);
        @(negedge clk); chk("t5_ready_high_after", s_ready, 1);
        t = 0;
        while (drv_active && t < 10) begin @(posedge clk); #1; t++; end
        chk("t5_driver_stopped", drv_active, 0);
        stop_drv = 1'b0;
        exp_q.delete();
        send_frame(11, 100, st, la);
        idle();
        chk("t5_no_stall", st, 0);
        wait_done(10, N + DEC_CYCLES + 100, "t5_done_timeout");
        chk("t5_burst_start", mon_bstart, la + 2);

        repeat (10) @(posedge clk);
        #1;
        chk("final_done_count", mon_ndone, 10);
        chk("final_burst_count", mon_nburst, 11);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
